// File: rtl/wb_line_adapter.sv
// 32-bit Wishbone classic to 128-bit line adapter with a one-line read buffer and write-through merge.
// Latency: hit 1 cycle, miss/write add downstream cycles; a stalled m_ack_i stalls the upstream ack.
module wb_line_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    s_cyc_i,
    input  logic                    s_stb_i,
    input  logic                    s_we_i,
    input  logic [ADDR_WIDTH-1:0]   s_addr_i,
    input  logic [DATA_WIDTH-1:0]   s_data_i,
    input  logic [DATA_WIDTH/8-1:0] s_sel_i,
    output logic [DATA_WIDTH-1:0]   s_data_o,
    output logic                    s_ack_o,
    input  logic                    flush_i,
    output logic                    m_cyc_o,
    output logic                    m_stb_o,
    output logic                    m_we_o,
    output logic [ADDR_WIDTH-1:0]   m_addr_o,
    output logic [LINE_WIDTH-1:0]   m_data_o,
    input  logic [LINE_WIDTH-1:0]   m_data_i,
    input  logic                    m_ack_i
);
    localparam int SEL_W  = DATA_WIDTH / 8;
    localparam int LANES  = LINE_WIDTH / DATA_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BOFF   = $clog2(SEL_W);
    localparam int LOFF   = $clog2(LINE_WIDTH / 8);
    localparam int TAG_W  = ADDR_WIDTH - LOFF;

    typedef enum logic [2:0] {IDLE, FETCH, MERGE, WRBACK, RESP} state_t;

    state_t                state_q, state_d;
    logic                  req_we;
    logic [TAG_W-1:0]      req_tag;
    logic [LANE_W-1:0]     req_lane;
    logic [DATA_WIDTH-1:0] req_data;
    logic [SEL_W-1:0]      req_sel;
    logic [LINE_WIDTH-1:0] buf_line;
    logic [TAG_W-1:0]      buf_tag;
    logic                  buf_valid;
    logic [LINE_WIDTH-1:0] merged;
    logic [TAG_W-1:0]      in_tag;
    logic [LANE_W-1:0]     in_lane;
    logic                  req;
    logic                  hit;
    logic                  unused_addr_bits;

    assign in_tag  = s_addr_i[ADDR_WIDTH-1:LOFF];
    assign in_lane = (LANES > 1) ? s_addr_i[BOFF +: LANE_W] : '0;
    assign req     = s_cyc_i && s_stb_i;
    // flush wins over a matching tag so a same-cycle request always misses
    assign hit     = buf_valid && (buf_tag == in_tag) && !flush_i;
    assign unused_addr_bits = ^s_addr_i[BOFF-1:0];

    assign m_stb_o = (state_q == FETCH) || (state_q == WRBACK);
    assign m_cyc_o = m_stb_o;
    assign m_we_o  = (state_q == WRBACK);
    assign s_ack_o = (state_q == RESP);

    function automatic logic [DATA_WIDTH-1:0] lane_of(input logic [LINE_WIDTH-1:0] line,
                                                      input logic [LANE_W-1:0] lane);
        return line[int'(lane)*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    always_comb begin
        merged = buf_line;
        for (int b = 0; b < SEL_W; b++) begin
            if (req_sel[b]) begin
                merged[int'(req_lane)*DATA_WIDTH + b*8 +: 8] = req_data[b*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (s_we_i && (s_sel_i == '0)) state_d = RESP;
                    else if (hit)                  state_d = s_we_i ? MERGE : RESP;
                    else                           state_d = FETCH;
                end
            end
            FETCH:   if (m_ack_i) state_d = req_we ? MERGE : RESP;
            // MERGE keeps the strobe low between fetch and writeback
            MERGE:   state_d = WRBACK;
            WRBACK:  if (m_ack_i) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            buf_valid <= 1'b0;
            buf_line  <= '0;
            buf_tag   <= '0;
            req_we    <= 1'b0;
            req_tag   <= '0;
            req_lane  <= '0;
            req_data  <= '0;
            req_sel   <= '0;
            s_data_o  <= '0;
            m_addr_o  <= '0;
            m_data_o  <= '0;
        end else begin
            state_q  <= state_d;
            s_data_o <= '0;
            if (flush_i) buf_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        req_we   <= s_we_i;
                        req_tag  <= in_tag;
                        req_lane <= in_lane;
                        req_data <= s_data_i;
                        req_sel  <= s_sel_i;
                        m_addr_o <= {in_tag, {LOFF{1'b0}}};
                        if (!s_we_i && hit) s_data_o <= lane_of(buf_line, in_lane);
                    end
                end
                FETCH: begin
                    if (m_ack_i) begin
                        buf_line <= m_data_i;
                        buf_tag  <= req_tag;
                        if (!flush_i) buf_valid <= 1'b1;
                        if (!req_we)  s_data_o  <= lane_of(m_data_i, req_lane);
                    end
                end
                MERGE: begin
                    m_data_o <= merged;
                    buf_line <= merged;
                end
                WRBACK: begin
                    if (m_ack_i && !flush_i) buf_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
